// File: rtl/morse_pkg.sv
// Shared encodings, FSM states and width helper for the Morse letter receiver.
package morse_pkg;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EMIT
  } state_e;

  function automatic int len_width(input int max_symbols);
    return $clog2(max_symbols + 1);
  endfunction

endpackage

// File: rtl/morse_debounce.sv
// One key: 2-flop synchroniser, tick-qualified stability counter, press-event pulse.
module morse_debounce #(
  parameter int DEBOUNCE_TICKS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  input  logic tick,
  output logic press
);

  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          acc_q, acc_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          raw;

  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    raw     = ~sync2_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (tick) begin
      if (raw != acc_q) begin
        if (cnt_q == DW'(DEBOUNCE_TICKS - 1)) begin
          acc_d = raw;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
    // Only the released-to-pressed edge is reported; release just re-arms.
    press = acc_d & ~acc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/morse_letter_rx.sv
// Collects a 1..MAX_SYMBOLS Morse letter from debounced dot/dash keys and strobes it out.
module morse_letter_rx
  import morse_pkg::*;
#(
  parameter  int TICK_DIV       = 270000,
  parameter  int DEBOUNCE_TICKS = 2,
  parameter  int GAP_TICKS      = 50,
  parameter  int MAX_SYMBOLS    = 4,
  localparam int LW             = len_width(MAX_SYMBOLS)
) (
  input  logic                   CLKin,
  input  logic                   RSTin,
  input  logic                   dot_n,
  input  logic                   dash_n,
  input  logic                   clear,
  output logic [MAX_SYMBOLS-1:0] code,
  output logic [LW-1:0]          length,
  output logic                   valid,
  output logic                   busy,
  output logic                   collision
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int GW = $clog2(GAP_TICKS + 1);

  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic                   tick;
  logic                   dot_ev, dash_ev, sym_ev, sym;

  state_e                 state_q, state_d;
  logic [LW-1:0]          idx_q, idx_d, base_idx;
  logic [GW-1:0]          gap_q, gap_d;
  logic [MAX_SYMBOLS-1:0] work_q, work_d;
  logic [MAX_SYMBOLS-1:0] code_q, code_d;
  logic [LW-1:0]          length_q, length_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   collision_q, collision_d;

  always_comb begin
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  morse_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_dot (
    .clk(CLKin), .rst(RSTin), .key_n(dot_n), .tick(tick), .press(dot_ev)
  );

  morse_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_dash (
    .clk(CLKin), .rst(RSTin), .key_n(dash_n), .tick(tick), .press(dash_ev)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    work_d      = work_q;
    code_d      = code_q;
    length_d    = length_q;
    valid_d     = 1'b0;
    base_idx    = idx_q;
    // A same-tick press on both keys is ambiguous: flag it, record nothing.
    collision_d = collision_q | (dot_ev & dash_ev);
    sym_ev      = dot_ev ^ dash_ev;
    sym         = dash_ev ? SYM_DASH : SYM_DOT;

    case (state_q)
      IDLE, COLLECT: begin
        if (clear) begin
          state_d = IDLE;
          idx_d   = '0;
          gap_d   = '0;
          work_d  = '0;
        end else begin
          if (sym_ev) begin
            // A new letter starts from a clean working register.
            base_idx = (state_q == IDLE) ? '0 : idx_q;
            work_d   = (state_q == IDLE) ? '0 : work_q;
            for (int i = 0; i < MAX_SYMBOLS; i++) begin
              if (base_idx == LW'(i)) work_d[i] = sym;
            end
            idx_d   = (base_idx == LW'(MAX_SYMBOLS)) ? base_idx : base_idx + 1'b1;
            gap_d   = '0;
            state_d = COLLECT;
          end else if (tick && state_q == COLLECT && gap_q != GW'(GAP_TICKS)) begin
            gap_d = gap_q + 1'b1;
          end
          if (state_d == COLLECT &&
              (idx_d == LW'(MAX_SYMBOLS) || gap_d == GW'(GAP_TICKS))) begin
            state_d  = EMIT;
            valid_d  = 1'b1;
            code_d   = work_d;
            length_d = idx_d;
          end
        end
      end
      EMIT: begin
        state_d = IDLE;
        idx_d   = '0;
        gap_d   = '0;
        work_d  = '0;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == COLLECT);
  end

  always_ff @(posedge CLKin) begin
    if (RSTin) begin
      tick_cnt_q  <= '0;
      state_q     <= IDLE;
      idx_q       <= '0;
      gap_q       <= '0;
      work_q      <= '0;
      code_q      <= '0;
      length_q    <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      work_q      <= work_d;
      code_q      <= code_d;
      length_q    <= length_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      collision_q <= collision_d;
    end
  end

  assign code      = code_q;
  assign length    = length_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_morse_letter_rx.sv
// Directed bench for morse_letter_rx with a fast tick (4 clocks per tick).
module tb_morse_letter_rx;

  localparam int TD  = 4;
  localparam int DEB = 2;
  localparam int GAP = 8;
  localparam int MAX = 4;
  localparam int LW  = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           dot_n = 1'b1;
  logic           dash_n = 1'b1;
  logic           clear = 1'b0;
  logic [MAX-1:0] code;
  logic [LW-1:0]  length;
  logic           valid, busy, collision;

  int vectors = 0;
  int errors  = 0;

  int             cyc = 0;
  int             vcount = 0;
  int             valid_cyc = 0;
  int             busy_rise_cyc = 0;
  int             busy_rises = 0;
  logic           busy_prev = 1'b0;
  logic           busy_at_valid = 1'b0;
  logic [MAX-1:0] last_code = '0;
  logic [LW-1:0]  last_len = '0;

  morse_letter_rx #(
    .TICK_DIV(TD), .DEBOUNCE_TICKS(DEB), .GAP_TICKS(GAP), .MAX_SYMBOLS(MAX)
  ) dut (
    .CLKin(clk), .RSTin(rst), .dot_n(dot_n), .dash_n(dash_n), .clear(clear),
    .code(code), .length(length), .valid(valid), .busy(busy), .collision(collision)
  );

  always #5 clk = ~clk;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc       <= cyc + 1;
    busy_prev <= busy;
    if (valid === 1'b1) begin
      vcount    <= vcount + 1;
      valid_cyc <= cyc;
      last_code <= code;
      last_len  <= length;
      if (busy !== 1'b0) busy_at_valid <= 1'b1;
    end
    if (busy === 1'b1 && busy_prev !== 1'b1) begin
      busy_rise_cyc <= cyc;
      busy_rises    <= busy_rises + 1;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    cycles(n * TD);
  endtask

  task automatic key(input logic is_dash, input int hold, input int rel);
    if (is_dash) dash_n = 1'b0; else dot_n = 1'b0;
    ticks(hold);
    dash_n = 1'b1;
    dot_n  = 1'b1;
    ticks(rel);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cycles(3);
    vectors++; if (code !== 4'b0000) begin errors++; $display("FAIL reset_code: got %b want %b", code, 4'b0000); end
    vectors++; if (length !== 3'd0) begin errors++; $display("FAIL reset_length: got %0d want 0", length); end
    vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (collision !== 1'b0) begin errors++; $display("FAIL reset_collision: got %b want 0", collision); end
    rst = 1'b0;
    cycles(1);
  endtask

  task automatic test_full_letter;
    int v0;
    v0 = vcount;
    key(1'b0, 4, 4);
    key(1'b1, 4, 4);
    key(1'b0, 4, 4);
    key(1'b1, 4, 4);
    vectors++; if (vcount !== v0 + 1) begin errors++; $display("FAIL full_valid_count: got %0d want %0d", vcount - v0, 1); end
    vectors++; if (last_code !== 4'b1010) begin errors++; $display("FAIL full_code: got %b want 1010", last_code); end
    vectors++; if (last_len !== 3'd4) begin errors++; $display("FAIL full_length: got %0d want 4", last_len); end
    vectors++; if (busy_at_valid !== 1'b0) begin errors++; $display("FAIL full_busy_at_valid: got %b want 0", busy_at_valid); end
    vectors++; if (code !== 4'b1010 || length !== 3'd4) begin errors++; $display("FAIL full_hold: got %b/%0d want 1010/4", code, length); end
  endtask

  task automatic test_gap_timeout;
    int v0;
    v0 = vcount;
    key(1'b1, 4, 14);
    vectors++; if (vcount !== v0 + 1) begin errors++; $display("FAIL gap_valid_count: got %0d want 1", vcount - v0); end
    vectors++; if (valid_cyc - busy_rise_cyc !== GAP * TD) begin errors++; $display("FAIL gap_latency: got %0d want %0d cycles", valid_cyc - busy_rise_cyc, GAP * TD); end
    vectors++; if (last_code !== 4'b0001) begin errors++; $display("FAIL gap_code: got %b want 0001", last_code); end
    vectors++; if (last_len !== 3'd1) begin errors++; $display("FAIL gap_length: got %0d want 1", last_len); end
  endtask

  task automatic test_glitch;
    int v0, r0;
    v0 = vcount;
    r0 = busy_rises;
    dot_n = 1'b0;
    cycles(TD);
    dot_n = 1'b1;
    ticks(4);
    vectors++; if (busy !== 1'b0 || busy_rises !== r0) begin errors++; $display("FAIL glitch_busy: got busy=%b rises=%0d want 0/0", busy, busy_rises - r0); end
    key(1'b0, 3, 14);
    vectors++; if (busy_rises !== r0 + 1) begin errors++; $display("FAIL glitch_accept: got %0d letters want 1", busy_rises - r0); end
    vectors++; if (vcount !== v0 + 1) begin errors++; $display("FAIL glitch_valid_count: got %0d want 1", vcount - v0); end
    vectors++; if (last_code !== 4'b0000 || last_len !== 3'd1) begin errors++; $display("FAIL glitch_letter: got %b/%0d want 0000/1", last_code, last_len); end
  endtask

  task automatic test_collision;
    int v0, r0;
    v0 = vcount;
    r0 = busy_rises;
    vectors++; if (collision !== 1'b0) begin errors++; $display("FAIL coll_initial: got %b want 0", collision); end
    dot_n  = 1'b0;
    dash_n = 1'b0;
    ticks(4);
    dot_n  = 1'b1;
    dash_n = 1'b1;
    ticks(4);
    vectors++; if (collision !== 1'b1) begin errors++; $display("FAIL coll_set: got %b want 1", collision); end
    vectors++; if (busy_rises !== r0 || busy !== 1'b0) begin errors++; $display("FAIL coll_no_symbol: got %0d letters busy=%b want 0/0", busy_rises - r0, busy); end
    key(1'b0, 4, 14);
    vectors++; if (vcount !== v0 + 1) begin errors++; $display("FAIL coll_next_letter: got %0d want 1", vcount - v0); end
    vectors++; if (collision !== 1'b1) begin errors++; $display("FAIL coll_sticky: got %b want 1", collision); end
  endtask

  task automatic test_clear;
    int v0, r0;
    v0 = vcount;
    r0 = busy_rises;
    key(1'b0, 4, 4);
    dash_n = 1'b0;
    ticks(4);
    dash_n = 1'b1;
    ticks(1);
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_pre_busy: got %b want 1", busy); end
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    cycles(2);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy: got %b want 0", busy); end
    ticks(12);
    vectors++; if (vcount !== v0) begin errors++; $display("FAIL clear_no_valid: got %0d want 0", vcount - v0); end
    vectors++; if (code !== 4'b0000 || length !== 3'd1) begin errors++; $display("FAIL clear_outputs_kept: got %b/%0d want 0000/1", code, length); end
    vectors++; if (busy_rises !== r0 + 1) begin errors++; $display("FAIL clear_letters: got %0d want 1", busy_rises - r0); end
  endtask

  task automatic test_reset_mid;
    int v0;
    v0 = vcount;
    dot_n = 1'b0;
    ticks(4);
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre: got %b want 1", busy); end
    rst   = 1'b1;
    dot_n = 1'b1;
    cycles(4);
    vectors++; if (code !== 4'b0000 || length !== 3'd0) begin errors++; $display("FAIL rstmid_code_len: got %b/%0d want 0000/0", code, length); end
    vectors++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_valid_busy: got %b/%b want 0/0", valid, busy); end
    vectors++; if (collision !== 1'b0) begin errors++; $display("FAIL rstmid_collision: got %b want 0", collision); end
    rst = 1'b0;
    ticks(14);
    vectors++; if (vcount !== v0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_no_valid: got %0d valids busy=%b want 0/0", vcount - v0, busy); end
  endtask

  task automatic test_hold;
    int v0, r0;
    v0 = vcount;
    r0 = busy_rises;
    key(1'b0, 30, 14);
    vectors++; if (vcount !== v0 + 1) begin errors++; $display("FAIL hold_valid_count: got %0d want 1", vcount - v0); end
    vectors++; if (busy_rises !== r0 + 1) begin errors++; $display("FAIL hold_letters: got %0d want 1", busy_rises - r0); end
    vectors++; if (last_code !== 4'b0000 || last_len !== 3'd1) begin errors++; $display("FAIL hold_letter: got %b/%0d want 0000/1", last_code, last_len); end
    vectors++; if (code !== 4'b0000 || length !== 3'd1) begin errors++; $display("FAIL hold_outputs: got %b/%0d want 0000/1", code, length); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_full_letter;
    test_gap_timeout;
    test_glitch;
    test_collision;
    test_clear;
    test_reset_mid;
    test_hold;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/morse_letter_rx.md
Name: morse_letter_rx

Overview:
- Parametrised successor to the fixed 4-symbol Morse capture logic.
- Debounces two active-low keys: dot records a 0, dash records a 1.
- Collects a variable-length letter of 1..MAX_SYMBOLS symbols. A letter ends when it is full or after an inter-letter silence timeout.
- Presents the code, its length and a one-cycle valid strobe to the downstream decoder/display logic. Runs on the board clock with an internal tick divider instead of a derived clock.

Parameters:
- TICK_DIV, 270000: CLKin cycles per sampling tick (10 ms at 27 MHz); minimum 2.
- DEBOUNCE_TICKS, 2: consecutive ticks a raw key level must be stable before it is accepted; minimum 1.
- GAP_TICKS, 50: silent ticks after the last accepted symbol that close the letter; minimum 1.
- MAX_SYMBOLS, 4: maximum symbols per letter; range 1..8.

Ports:
- CLKin, input, 1: system clock.
- RSTin, input, 1: synchronous reset, active-high.
- dot_n, input, 1: dot key, active-low, asynchronous to CLKin.
- dash_n, input, 1: dash key, active-low, asynchronous to CLKin.
- clear, input, 1: abort the current letter.
- code, output, MAX_SYMBOLS: captured letter. Bit i is symbol i in entry order; 0 = dot, 1 = dash.
- length, output, LW = $clog2(MAX_SYMBOLS+1): number of valid symbols in code.
- valid, output, 1: one-cycle strobe; code and length are new this cycle.
- busy, output, 1: high while a letter is being collected.
- collision, output, 1: sticky flag, set when both keys are accepted pressed on the same tick.

Behaviour:
- Reset (RSTin=1 at a CLKin edge) sets code=0, length=0, valid=0, busy=0 and collision=0. It also clears the tick counter, debounce state (both keys released), gap counter and symbol index, and puts the FSM in IDLE. Reset mid-letter discards the partial letter and produces no valid.
- Inputs: each key passes through a 2-flop synchroniser before the debouncer.
- Tick: a free-running counter 0..TICK_DIV-1. tick is high for the one cycle in which the counter wraps.
- Debounce: evaluated only on tick. The accepted level changes once the synchronised raw level has differed from it on DEBOUNCE_TICKS consecutive ticks.
- Press event: an accepted released-to-pressed transition. Press events occur only on tick cycles. Release events are ignored except to re-arm the key.
- Simultaneous press events on the same tick: no symbol is recorded and collision is set to 1. collision is cleared only by RSTin.
- FSM states are IDLE, COLLECT and EMIT.
  - IDLE: busy=0. A press event writes the symbol at index 0, sets index=1, clears the gap counter and moves to COLLECT.
  - COLLECT: busy=1. A press event writes code_work[index], increments index and clears the gap counter. Each tick with no event increments the gap counter.
  - COLLECT to EMIT: index reaches MAX_SYMBOLS, or the gap counter reaches GAP_TICKS.
  - EMIT: lasts exactly one cycle and returns to IDLE. In that cycle code and length load from the working registers and valid=1. Unused upper code bits are 0.
- Latency: valid rises one CLKin cycle after the tick on which the final symbol is accepted (full case), or after the tick on which the gap counter reaches GAP_TICKS (timeout case).
- code and length hold their values until the next EMIT. They are not cleared by IDLE or by clear.
- clear: in COLLECT or IDLE, it discards the working registers and forces IDLE with no valid. clear takes priority over a same-cycle press event. clear during EMIT is ignored, and the strobe completes.
- A key held down never produces a second symbol. It must be released and re-pressed.
- Width: the index and gap counters saturate and never wrap. length equals index truncated to LW bits, which is always exact.

Decomposition:
- Shared package morse_pkg:
  - symbol encodings SYM_DOT=1'b0 and SYM_DASH=1'b1;
  - FSM state enum {IDLE, COLLECT, EMIT};
  - a width helper function for LW.
- Sub-module morse_debounce: synchroniser, tick-qualified stable counter and press-event output. It is instantiated twice, once per key; the tick is shared from the parent.

Test Plan (TICK_DIV=4, DEBOUNCE_TICKS=2, GAP_TICKS=8, MAX_SYMBOLS=4):
- Press and release dot, dash, dot, dash, each pressed and released for 4 ticks → one valid pulse after the 4th accepted press, code=4'b1010, length=3'd4, busy falls with valid.
- Dash only, then 10 silent ticks → valid exactly 8 ticks after acceptance, code=4'b0001, length=3'd1.
- 1-tick glitch on dot_n → no symbol, busy stays 0; a 3-tick press → symbol accepted.
- Both keys pressed on the same tick → no symbol, collision=1 and stays 1 until RSTin.
- Two symbols, then clear → no valid, busy=0, and previous code/length unchanged. Assert RSTin mid-letter → all outputs 0.
- Hold dot for 30 ticks → exactly one symbol. Letter times out with code=4'b0000, length=3'd1.
